// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM receive demultiplexer: default geometry,
// FSM state encodings and a constant-foldable clog2 helper.
package tdm_demux_pkg;

  localparam int DEF_CHANNELS = 2;
  localparam int DEF_WIDTH    = 8;

  localparam logic [0:0] ST_HUNT = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  // Returns at least 1 so counters never collapse to zero width.
  function automatic int clog2(input int n);
    int r;
    r = 32'sd0;
    while ((32'sd1 <<< r) < n) begin
      r = r + 32'sd1;
    end
    if (r < 32'sd1) begin
      r = 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tdm_slot_shifter.sv
// Serial-to-parallel slot assembler: WIDTH-bit shift register and bit counter.
// A clear beat restarts the slot with the current bit as bit 0.
module tdm_slot_shifter
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       shift_en,
  input  logic                       clear,
  input  logic                       din,
  output logic [WIDTH-1:0]           word,
  output logic [clog2(WIDTH)-1:0]    bit_cnt,
  output logic                       slot_done
);

  localparam int BIT_W = clog2(WIDTH);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1'b1);

  logic [WIDTH-1:0] sr_r;
  logic [BIT_W-1:0] bit_cnt_r;
  logic [BIT_W-1:0] bit_cnt_nxt_s;

  // Next bit position: clear restarts at 1 because the clearing bit is itself bit 0.
  always_comb begin
    bit_cnt_nxt_s = bit_cnt_r;
    if (clear) begin
      bit_cnt_nxt_s = BIT_ONE;
    end else if (bit_cnt_r == BIT_LAST) begin
      bit_cnt_nxt_s = '0;
    end else begin
      bit_cnt_nxt_s = bit_cnt_r + BIT_ONE;
    end
  end

  // Shift register and bit counter advance only on accepted beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_r      <= '0;
      bit_cnt_r <= '0;
    end else if (shift_en) begin
      sr_r      <= {sr_r[WIDTH-2:0], din};
      bit_cnt_r <= bit_cnt_nxt_s;
    end else begin
      sr_r      <= sr_r;
      bit_cnt_r <= bit_cnt_r;
    end
  end

  assign word      = {sr_r[WIDTH-2:0], din};
  assign bit_cnt   = bit_cnt_r;
  assign slot_done = shift_en & ~clear & (bit_cnt_r == BIT_LAST);

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: assembles CHANNELS serial slots per frame and
// steers each completed slot to its own output register with a valid strobe.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int WIDTH    = DEF_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        din,
  input  logic                        din_valid,
  input  logic                        frame_sync,
  output logic [CHANNELS*WIDTH-1:0]   ch_data,
  output logic [CHANNELS-1:0]         ch_valid,
  output logic                        frame_done,
  output logic                        sync_err,
  output logic                        busy
);

  localparam int SLOT_W = clog2(CHANNELS);
  localparam int BIT_W  = clog2(WIDTH);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(CHANNELS - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1'b1);

  logic [0:0]                state_r;
  logic [0:0]                state_nxt_s;
  logic [SLOT_W-1:0]         slot_cnt_r;
  logic [SLOT_W-1:0]         slot_cnt_nxt_s;
  logic [CHANNELS*WIDTH-1:0] ch_data_r;
  logic [CHANNELS-1:0]       ch_valid_r;
  logic [CHANNELS-1:0]       valid_nxt_s;
  logic                      frame_done_r;
  logic                      sync_err_r;
  logic                      busy_r;

  logic                      sync_beat_s;
  logic                      shift_en_s;
  logic                      slot_done_s;
  logic                      frame_end_s;
  logic                      err_s;
  logic [WIDTH-1:0]          word_s;
  logic [BIT_W-1:0]          bit_cnt_s;

  // In HUNT only a sync beat is accepted; everything else is dropped.
  assign sync_beat_s = din_valid & frame_sync;
  assign shift_en_s  = din_valid & ((state_r == ST_RECV) | frame_sync);
  assign frame_end_s = slot_done_s & (slot_cnt_r == SLOT_LAST);
  assign err_s       = sync_beat_s & (state_r == ST_RECV) &
                       ((bit_cnt_s != '0) | (slot_cnt_r != '0));

  tdm_slot_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (shift_en_s),
    .clear     (sync_beat_s),
    .din       (din),
    .word      (word_s),
    .bit_cnt   (bit_cnt_s),
    .slot_done (slot_done_s)
  );

  // Frame FSM: enter RECV on sync, fall back to HUNT after the last slot.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_HUNT: begin
        if (sync_beat_s) begin
          state_nxt_s = ST_RECV;
        end else begin
          state_nxt_s = ST_HUNT;
        end
      end
      ST_RECV: begin
        if (frame_end_s) begin
          state_nxt_s = ST_HUNT;
        end else begin
          state_nxt_s = ST_RECV;
        end
      end
      default: state_nxt_s = ST_HUNT;
    endcase
  end

  // Slot index: any sync beat restarts the frame at slot 0.
  always_comb begin
    slot_cnt_nxt_s = slot_cnt_r;
    if (sync_beat_s) begin
      slot_cnt_nxt_s = '0;
    end else if (frame_end_s) begin
      slot_cnt_nxt_s = '0;
    end else if (slot_done_s) begin
      slot_cnt_nxt_s = slot_cnt_r + SLOT_ONE;
    end else begin
      slot_cnt_nxt_s = slot_cnt_r;
    end
  end

  // One-hot strobe for the slot completing on this beat.
  always_comb begin
    valid_nxt_s = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (slot_done_s && (slot_cnt_r == SLOT_W'(k))) begin
        valid_nxt_s[k] = 1'b1;
      end else begin
        valid_nxt_s[k] = 1'b0;
      end
    end
  end

  // Control state and single-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_HUNT;
      slot_cnt_r   <= '0;
      ch_valid_r   <= '0;
      frame_done_r <= 1'b0;
      sync_err_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      slot_cnt_r   <= slot_cnt_nxt_s;
      ch_valid_r   <= valid_nxt_s;
      frame_done_r <= frame_end_s;
      sync_err_r   <= err_s;
      busy_r       <= (state_nxt_s == ST_RECV);
    end
  end

  // Completed slot lands in its own slice; other slices hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_data_r <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (valid_nxt_s[k]) begin
          ch_data_r[k*WIDTH +: WIDTH] <= word_s;
        end else begin
          ch_data_r[k*WIDTH +: WIDTH] <= ch_data_r[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign ch_data    = ch_data_r;
  assign ch_valid   = ch_valid_r;
  assign frame_done = frame_done_r;
  assign sync_err   = sync_err_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed frames from the test plan plus
// random beats, checked each cycle against a slot-level behavioural model.
module tb_tdm_demux;

  localparam int CH = 2;
  localparam int W  = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            din;
  logic            din_valid;
  logic            frame_sync;
  logic [CH*W-1:0] ch_data;
  logic [CH-1:0]   ch_valid;
  logic            frame_done;
  logic            sync_err;
  logic            busy;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: expected outputs and frame progress.
  logic [CH*W-1:0] e_data;
  logic [CH-1:0]   e_valid;
  bit              e_fd, e_err, m_active;
  int              m_bits, m_slot, m_word;
  int              obs_fd, obs_valid, obs_err;
  int              gap_every, gap_cnt;
  int              fd0, va0, er0;

  tdm_demux #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .ch_data    (ch_data),
    .ch_valid   (ch_valid),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_data = '0; e_valid = '0; e_fd = 0; e_err = 0;
    m_active = 0; m_bits = 0; m_slot = 0; m_word = 0;
  endtask

  // Slot-level rules: sync restarts a frame, WIDTH bits make a slot, CH slots a frame.
  task automatic model_beat(input bit v, input bit s, input bit d);
    e_valid = '0; e_fd = 0; e_err = 0;
    if (v) begin
      if (s) begin
        if (m_active && (m_bits != 0 || m_slot != 0)) e_err = 1;
        m_active = 1; m_slot = 0; m_bits = 1; m_word = int'(d);
      end else if (m_active) begin
        m_word = (m_word * 2 + int'(d)) % (1 << W);
        m_bits++;
        if (m_bits == W) begin
          e_data[m_slot*W +: W] = m_word[W-1:0];
          e_valid[m_slot] = 1'b1;
          m_bits = 0;
          if (m_slot == CH - 1) begin
            e_fd = 1; m_active = 0; m_slot = 0;
          end else begin
            m_slot++;
          end
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ch_data"}, 64'(ch_data), 64'(e_data));
    chk({tag, ".ch_valid"}, 64'(ch_valid), 64'(e_valid));
    chk({tag, ".frame_done"}, 64'(frame_done), 64'(e_fd));
    chk({tag, ".sync_err"}, 64'(sync_err), 64'(e_err));
    chk({tag, ".busy"}, 64'(busy), 64'(m_active));
    chk({tag, ".onehot"}, 64'($onehot0(ch_valid)), 64'd1);
  endtask

  task automatic cycle(input bit v, input bit s, input bit d);
    din_valid = v; frame_sync = s; din = d;
    @(posedge clk);
    model_beat(v, s, d);
    #1;
    check_all("cyc");
    obs_fd    += int'(frame_done);
    obs_valid += $countones(ch_valid);
    obs_err   += int'(sync_err);
    @(negedge clk);
  endtask

  task automatic beat(input bit s, input bit d);
    cycle(1'b1, s, d);
    gap_cnt++;
    if (gap_every > 0 && (gap_cnt % gap_every) == 0) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_word(input logic [W-1:0] w, input bit sync_first);
    for (int i = W - 1; i >= 0; i--) beat(sync_first && (i == W - 1), w[i]);
  endtask

  initial begin
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
    obs_fd = 0; obs_valid = 0; obs_err = 0; gap_every = 0; gap_cnt = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_all("reset");

    // Nominal frame 0xA5, 0x3C
    send_word(8'hA5, 1'b1);
    chk("t2.valid0", 64'(ch_valid), 64'h1);
    chk("t2.slot0", 64'(ch_data[7:0]), 64'hA5);
    send_word(8'h3C, 1'b0);
    chk("t2.valid1", 64'(ch_valid), 64'h2);
    chk("t2.fd", 64'(frame_done), 64'h1);
    chk("t2.data", 64'(ch_data), 64'h3CA5);
    cycle(1'b0, 1'b0, 1'b0);
    chk("t2.busy", 64'(busy), 64'h0);

    // Reset asserted between edges mid-frame
    send_word(8'hFF, 1'b1);
    beat(1'b0, 1'b1);
    chk("t1.busy_pre", 64'(busy), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t1.async");
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 1'b0);

    // Gapped input after every 3rd bit
    gap_every = 3; gap_cnt = 0;
    send_word(8'hA5, 1'b1);
    send_word(8'h3C, 1'b0);
    gap_every = 0;
    chk("t3.data", 64'(ch_data), 64'h3CA5);
    chk("t3.fd", 64'(frame_done), 64'h1);

    // Hunt discard
    er0 = obs_err;
    repeat (5) cycle(1'b1, 1'b0, 1'b1);
    chk("t4.busy", 64'(busy), 64'h0);
    send_word(8'h12, 1'b1);
    send_word(8'h34, 1'b0);
    chk("t4.data", 64'(ch_data), 64'h3412);
    chk("t4.noerr", 64'(obs_err - er0), 64'h0);

    // Mid-frame resync
    er0 = obs_err; fd0 = obs_fd;
    send_word(8'h77, 1'b1);
    chk("t5.slot0", 64'(ch_data), 64'h3477);
    for (int i = 0; i < 3; i++) beat(1'b0, i[0]);
    send_word(8'h11, 1'b1);
    send_word(8'h22, 1'b0);
    chk("t5.err", 64'(obs_err - er0), 64'h1);
    chk("t5.fd", 64'(obs_fd - fd0), 64'h1);
    chk("t5.data", 64'(ch_data), 64'h2211);

    // Back-to-back frames
    fd0 = obs_fd; va0 = obs_valid;
    send_word(8'hC3, 1'b1);
    send_word(8'h5A, 1'b0);
    chk("t6.data1", 64'(ch_data), 64'h5AC3);
    send_word(8'h0F, 1'b1);
    send_word(8'hE1, 1'b0);
    chk("t6.data2", 64'(ch_data), 64'hE10F);
    chk("t6.fd", 64'(obs_fd - fd0), 64'h2);
    chk("t6.valid", 64'(obs_valid - va0), 64'h4);

    // Random beats with occasional sync
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(3, 0) != 0), ($urandom_range(19, 0) == 0), $urandom_range(1, 0) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
